// File: rtl/serial_pattern_detector.sv
// Bit-serial pattern detector: shifts valid bits into a window, pulses `match`
// on every (overlapping) occurrence of PATTERN, keeps a saturating match count.
module serial_pattern_detector #(
   parameter int unsigned            PATTERN_LEN = 4,
   parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
   parameter int unsigned            COUNT_W     = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   din,
   input  logic                   din_valid,
   input  logic                   clear,
   output logic [PATTERN_LEN-1:0] window,
   output logic                   match,
   output logic [COUNT_W-1:0]     match_count
);

   // Fill counter spans 0..PATTERN_LEN and is never narrower than 3 bits.
   localparam int unsigned FILL_W = ($clog2(PATTERN_LEN + 1) > 3) ? $clog2(PATTERN_LEN + 1) : 3;
   localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PATTERN_LEN);
   localparam logic [FILL_W-1:0]  FILL_ONE  = FILL_W'(1);
   localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

   logic [PATTERN_LEN-1:0] window_q, window_d;
   logic [FILL_W-1:0]      fill_q,   fill_d;
   logic                   match_q,  match_d;
   logic [COUNT_W-1:0]     count_q,  count_d;

   // Next-state: clear beats a valid bit; idle cycles hold everything but match.
   always_comb begin
      window_d = window_q;
      fill_d   = fill_q;
      match_d  = 1'b0;
      count_d  = count_q;
      if (clear) begin
         window_d = '0;
         fill_d   = '0;
         count_d  = '0;
      end else if (din_valid) begin
         window_d = {window_q[PATTERN_LEN-2:0], din};
         if (fill_q != FILL_FULL) begin
            fill_d = fill_q + FILL_ONE;
         end
         // Fill gating stops reset zeros from completing a pattern with leading zeros.
         match_d = (window_d == PATTERN) && (fill_d == FILL_FULL);
         if (match_d && (count_q != '1)) begin
            count_d = count_q + COUNT_ONE;
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         window_q <= '0;
         fill_q   <= '0;
         match_q  <= 1'b0;
         count_q  <= '0;
      end else begin
         window_q <= window_d;
         fill_q   <= fill_d;
         match_q  <= match_d;
         count_q  <= count_d;
      end
   end

   assign window      = window_q;
   assign match       = match_q;
   assign match_count = count_q;

endmodule
